sr_pulse_driver: RTL and testbench

Debounces two raw, active-high request inputs and converts each debounced rising edge into a fixed-length, registered pulse on the matching output. The block sits directly upstream of the SR latch: out0 drives latch in0 and out1 drives latch in1. The block guarantees the latch never sees both inputs high together, and guarantees a minimum idle gap between pulses.

---
 rtl/sr_pulse_driver.sv | 185 ++++++++++++++++++
 tb/tb_sr_pulse_driver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: debounced request to fixed-length SR-latch pulse driver.
// Two raw requests are debounced, rising edges queue a pending request,
// and a small FSM issues mutually exclusive pulses with an idle gap.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   in0  - raw request, channel 0 (may bounce)
//   in1  - raw request, channel 1 (may bounce)
//   out0 - registered pulse to latch in0
//   out1 - registered pulse to latch in1
//   busy - registered: FSM not idle or a request pending
//
// Build option: define SR_INPUT_SYNC_EN to insert a two-flop
// synchronizer on each raw input (adds 2 edges of latency).
module sr_pulse_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 2,
    parameter int GAP_CYCLES      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in0,
    input  logic in1,
    output logic out0,
    output logic out1,
    output logic busy
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    localparam int CMAX = (PULSE_LEN > GAP_CYCLES) ? PULSE_LEN :
                          ((GAP_CYCLES > 1) ? GAP_CYCLES : 1);
    localparam int CW = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] P_LAST = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] G_LAST =
        CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE0 = 2'd1,
        PULSE1 = 2'd2,
        GAP    = 2'd3
    } state_t;

    logic [1:0] raw;
    logic [1:0] smp;

    assign raw = {in1, in0};

`ifdef SR_INPUT_SYNC_EN
    logic [1:0] sync1;
    logic [1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign smp = sync2;
`else
    assign smp = raw;
`endif

    // Debouncer: the counter only runs while the sample disagrees with
    // the stable level, and clears on acceptance, so it never saturates.
    logic [1:0] stable;

    for (genvar i = 0; i < 2; i++) begin : g_db
        logic          s_q;
        logic [DW-1:0] c_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                s_q <= 1'b0;
                c_q <= '0;
            end else if (smp[i] == s_q) begin
                c_q <= '0;
            end else if (c_q == DB_LAST) begin
                s_q <= smp[i];
                c_q <= '0;
            end else begin
                c_q <= c_q + 1'b1;
            end
        end

        assign stable[i] = s_q;
    end

    logic [1:0] stable_d;
    logic [1:0] rise;
    logic [1:0] req;
    logic [1:0] req_n;
    logic [1:0] take;

    assign rise = stable & ~stable_d;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          arb;
    logic          busy_n;

    // Expiry of a pulse (with no gap) or of the gap arbitrates in the
    // same cycle, so back-to-back requests lose no extra idle edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        arb     = 1'b0;
        take    = 2'b00;

        unique case (state)
            IDLE: begin
                arb = 1'b1;
            end
            PULSE0, PULSE1: begin
                if (cnt == P_LAST) begin
                    cnt_n = '0;
                    if (GAP_CYCLES == 0) begin
                        arb = 1'b1;
                    end else begin
                        state_n = GAP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == G_LAST) begin
                    arb = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (arb) begin
            cnt_n = '0;
            if (req[0]) begin
                state_n = PULSE0;
                take[0] = 1'b1;
            end else if (req[1]) begin
                state_n = PULSE1;
                take[1] = 1'b1;
            end else begin
                state_n = IDLE;
            end
        end

        // A fresh rise in the same cycle as service re-arms the request.
        req_n  = (req & ~take) | rise;
        busy_n = (state_n != IDLE) || (req_n != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d <= 2'b00;
            req      <= 2'b00;
            state    <= IDLE;
            cnt      <= '0;
            out0     <= 1'b0;
            out1     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            stable_d <= stable;
            req      <= req_n;
            state    <= state_n;
            cnt      <= cnt_n;
            out0     <= (state_n == PULSE0);
            out1     <= (state_n == PULSE1);
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb_sr_pulse_driver: directed and randomized checks of sr_pulse_driver
// against an event-time reference model.
module tb_sr_pulse_driver;

    localparam int D = 4;
    localparam int P = 2;
    localparam int G = 1;

`ifdef SR_INPUT_SYNC_EN
    localparam int X = 2;
`else
    localparam int X = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in0 = 1'b0;
    logic in1 = 1'b0;
    logic out0;
    logic out1;
    logic busy;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    sr_pulse_driver #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_LEN(P),
        .GAP_CYCLES(G)
    ) dut (
        .clk (clk),
        .rst (rst),
        .in0 (in0),
        .in1 (in1),
        .out0(out0),
        .out1(out1),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model in event time: a level is accepted once the input
    // has disagreed with it for D edges since the last agreeing edge; a
    // grant occupies the channel for P+G edges starting at the grant edge.
    int ecount  = 0;
    int free_at = 0;
    int gch     = -1;
    int gstart  = 0;
    int last_m[2];
    bit m_s[2];
    bit m_rise[2];
    bit m_req[2];
    bit m_out[2];
    bit m_busy;
    bit m_sy1[2];
    bit m_sy2[2];

    task automatic model_step();
        bit raw[2];
        bit smp;
        int e;
        raw[0] = in0;
        raw[1] = in1;
        ecount++;
        e = ecount;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_s[c]    = 0;
                m_rise[c] = 0;
                m_req[c]  = 0;
                m_out[c]  = 0;
                m_sy1[c]  = 0;
                m_sy2[c]  = 0;
                last_m[c] = e;
            end
            free_at = e;
            gch     = -1;
            m_busy  = 0;
            return;
        end
        if (e >= free_at) begin
            gch = -1;
            if (m_req[0]) gch = 0;
            else if (m_req[1]) gch = 1;
            if (gch >= 0) begin
                gstart     = e;
                free_at    = e + P + G;
                m_req[gch] = 0;
            end
        end
        for (int c = 0; c < 2; c++) begin
            if (m_rise[c]) m_req[c] = 1;
        end
        for (int c = 0; c < 2; c++) begin
`ifdef SR_INPUT_SYNC_EN
            smp      = m_sy2[c];
            m_sy2[c] = m_sy1[c];
            m_sy1[c] = raw[c];
`else
            smp = raw[c];
`endif
            m_rise[c] = 0;
            if (smp == m_s[c]) begin
                last_m[c] = e;
            end else if (e - last_m[c] >= D) begin
                m_s[c]    = smp;
                last_m[c] = e;
                m_rise[c] = smp;
            end
            m_out[c] = (gch == c) && (e < gstart + P);
        end
        m_busy = (e < free_at) || m_req[0] || m_req[1];
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out0_vs_model", out0, m_out[0]);
            chk("out1_vs_model", out1, m_out[1]);
            chk("busy_vs_model", busy, m_busy);
            chk("exclusive", out0 & out1, 1'b0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in0 = 1'b0;
        in1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int hold0;
    int hold1;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_out0", out0, 1'b0);
        chk("reset_out1", out1, 1'b0);
        chk("reset_busy", busy, 1'b0);

        // single request held high
        rst = 1'b0;
        in0 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            chk("s1_out0", out0, (k == 6 + X) || (k == 7 + X));
            chk("s1_out1", out1, 1'b0);
            chk("s1_model", m_out[0], (k == 6 + X) || (k == 7 + X));
            if (k == 5 + X) chk("s1_busy_req", busy, 1'b1);
            if (k == 9 + X) chk("s1_busy_idle", busy, 1'b0);
        end

        // falling edge produces nothing
        @(negedge clk);
        in0 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            chk("s4_no_pulse", out0, 1'b0);
        end

        // short bounces never accepted
        do_reset();
        for (int r = 0; r < 5; r++) begin
            in0 = 1'b1;
            repeat (3) @(negedge clk);
            in0 = 1'b0;
            repeat (2) @(negedge clk);
            chk("s2_out0", out0, 1'b0);
            chk("s2_out1", out1, 1'b0);
        end

        // simultaneous requests, channel 0 first
        do_reset();
        in0 = 1'b1;
        in1 = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            #1;
            chk("s3_out0", out0, (k == 6 + X) || (k == 7 + X));
            chk("s3_out1", out1, (k == 9 + X) || (k == 10 + X));
            chk("s3_model1", m_out[1], (k == 9 + X) || (k == 10 + X));
        end

        // reset during a pulse, input still held
        do_reset();
        in0 = 1'b1;
        repeat (6 + X) @(posedge clk);
        #1;
        chk("s5_pre_out0", out0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("s5_rst_out0", out0, 1'b0);
        chk("s5_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            chk("s5_again", out0, (k == 6 + X) || (k == 7 + X));
        end

        // randomized traffic with occasional reset
        do_reset();
        hold0 = 0;
        hold1 = 0;
        repeat (4000) begin
            @(negedge clk);
            if (hold0 == 0) begin
                in0   = 1'($urandom_range(0, 1));
                hold0 = $urandom_range(1, 9);
            end
            if (hold1 == 0) begin
                in1   = 1'($urandom_range(0, 1));
                hold1 = $urandom_range(1, 9);
            end
            hold0--;
            hold1--;
            rst = ($urandom_range(0, 249) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
